bit_serial_add_driver: RTL and testbench

Parallel front end for the `bit_serial_adder` datapath. It accepts two WIDTH-bit operands with a start strobe, streams them LSB-first onto the adder's serial `a`/`b` inputs, and collects the returned serial sum and final carry into a parallel result. It presents a parallel handshake to the rest of the design, and the adder sees the serial protocol it expects.

---
 rtl/bit_serial_add_driver_if.sv | 28 ++
 rtl/bit_serial_add_driver.sv | 98 +++++++++
 tb/tb_bit_serial_add_driver.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_add_driver_if.sv
// Signal bundle between the parallel-side client, the serial driver and the bit-serial adder.
// The slave modport is the driver's view; the master modport is the surrounding environment.
interface bit_serial_add_driver_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ser_a;
    logic             ser_b;
    logic             ser_rst;
    logic             ser_s;
    logic             ser_cout;

    modport slave (
        input  start, op_a, op_b, ser_s, ser_cout,
        output busy, done, sum, carry_out, ser_a, ser_b, ser_rst
    );

    modport master (
        output start, op_a, op_b, ser_s, ser_cout,
        input  busy, done, sum, carry_out, ser_a, ser_b, ser_rst
    );
endinterface

// File: rtl/bit_serial_add_driver.sv
// Parallel front end for a bit-serial adder: streams two operands LSB-first into the
// adder and reassembles the returned serial sum and final carry into a parallel result.
module bit_serial_add_driver #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    bit_serial_add_driver_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    assign last_bit = (state == SHIFT) && (cnt == LAST_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The final sum bit arrives combinationally on the last SHIFT edge, so the parallel
    // result is assembled from ser_s directly rather than from r after one more shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa      <= '0;
            sb      <= '0;
            r       <= '0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            sa  <= bus.op_a;
            sb  <= bus.op_b;
            cnt <= '0;
        end else if (state == SHIFT) begin
            r   <= {bus.ser_s, r[WIDTH-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + 1'b1;
            if (last_bit) begin
                sum_q   <= {bus.ser_s, r[WIDTH-1:1]};
                carry_q <= bus.ser_cout;
            end
        end
    end

    // Adder carry is held clear everywhere except SHIFT, so bit 0 always starts with carry 0.
    assign bus.ser_rst   = (state != SHIFT);
    assign bus.ser_a     = (state == SHIFT) && sa[0];
    assign bus.ser_b     = (state == SHIFT) && sb[0];
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_bit_serial_add_driver.sv
// Bench for bit_serial_add_driver with behavioural bit-serial adders at WIDTH 8 and 16.
module tb_bit_serial_add_driver;
    logic clk;
    logic reset;
    int   checks;
    int   fails;

    bit_serial_add_driver_if #(.WIDTH(8))  bus8();
    bit_serial_add_driver_if #(.WIDTH(16)) bus16();

    bit_serial_add_driver #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    bit_serial_add_driver #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bit-serial adders: combinational sum/carry, carry register cleared by ser_rst.
    logic c8, c16;
    assign bus8.ser_s     = bus8.ser_a ^ bus8.ser_b ^ c8;
    assign bus8.ser_cout  = (bus8.ser_a & bus8.ser_b) | (bus8.ser_a & c8) | (bus8.ser_b & c8);
    assign bus16.ser_s    = bus16.ser_a ^ bus16.ser_b ^ c16;
    assign bus16.ser_cout = (bus16.ser_a & bus16.ser_b) | (bus16.ser_a & c16) | (bus16.ser_b & c16);

    always @(posedge clk or posedge reset) begin
        if (reset)             c8 <= 1'b0;
        else if (bus8.ser_rst) c8 <= 1'b0;
        else                   c8 <= bus8.ser_cout;
    end

    always @(posedge clk or posedge reset) begin
        if (reset)              c16 <= 1'b0;
        else if (bus16.ser_rst) c16 <= 1'b0;
        else                    c16 <= bus16.ser_cout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the 8-bit instance: m_n counts edges since the accept edge.
    bit         m_act;
    int         m_n;
    logic [7:0] m_a, m_b, m_sum;
    logic       m_cout;
    logic       exp_shift;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 1'b0; m_n = 0; m_sum = '0; m_cout = 1'b0;
            m_a = '0; m_b = '0;
        end else if (m_act) begin
            m_n++;
            if (m_n == 8)      {m_cout, m_sum} = 9'(m_a) + 9'(m_b);
            else if (m_n == 9) m_act = 1'b0;
        end else if (bus8.start) begin
            m_act = 1'b1; m_n = 0; m_a = bus8.op_a; m_b = bus8.op_b;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_shift = m_act && (m_n < 8);
            chk("busy",      32'(bus8.busy),      32'(m_act));
            chk("done",      32'(bus8.done),      32'(m_act && (m_n == 8)));
            chk("ser_rst",   32'(bus8.ser_rst),   32'(!exp_shift));
            chk("ser_a",     32'(bus8.ser_a),     32'(exp_shift ? m_a[m_n[2:0]] : 1'b0));
            chk("ser_b",     32'(bus8.ser_b),     32'(exp_shift ? m_b[m_n[2:0]] : 1'b0));
            chk("sum",       32'(bus8.sum),       32'(m_sum));
            chk("carry_out", 32'(bus8.carry_out), 32'(m_cout));
        end
    end

    logic [7:0] seq8;
    int         dk[$];

    task automatic wait_idle8();
        int k = 0;
        while (bus8.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle8", 32'(bus8.busy), 32'd0);
    endtask

    task automatic wait_done8(input logic [7:0] es, input logic ec, input bit keep, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!keep) bus8.start = 1'b0;
            if (bus8.busy && !bus8.done) seq8 = {bus8.ser_a, seq8[7:1]};
        end while (!bus8.done && k < 40);
        chk({name, " latency"}, 32'(k - 1), 32'd8);
        chk({name, " sum"},     32'(bus8.sum), 32'(es));
        chk({name, " carry"},   32'(bus8.carry_out), 32'(ec));
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec, input string name);
        wait_idle8();
        bus8.op_a  = a;
        bus8.op_b  = b;
        bus8.start = 1'b1;
        wait_done8(es, ec, 1'b0, name);
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        logic [16:0] e;
        e = 17'(a) + 17'(b);
        while (bus16.busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        bus16.op_a  = a;
        bus16.op_b  = b;
        bus16.start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            bus16.start = 1'b0;
        end while (!bus16.done && k < 60);
        chk("rand16 latency", 32'(k - 1), 32'd16);
        chk("rand16 result",  32'({bus16.carry_out, bus16.sum}), 32'(e));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra, rb;
        logic [8:0]  re;
        int          pulses;
        checks = 0;
        fails  = 0;
        seq8   = '0;
        reset  = 1'b1;
        bus8.start  = 1'b0; bus8.op_a  = '0; bus8.op_b  = '0;
        bus16.start = 1'b0; bus16.op_a = '0; bus16.op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst busy",    32'(bus8.busy),      32'd0);
        chk("rst done",    32'(bus8.done),      32'd0);
        chk("rst sum",     32'(bus8.sum),       32'd0);
        chk("rst carry",   32'(bus8.carry_out), 32'd0);
        chk("rst ser_rst", 32'(bus8.ser_rst),   32'd1);
        chk("rst ser_a",   32'(bus8.ser_a),     32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op8(8'h31, 8'h14, 8'h45, 1'b0, "49+20");
        chk("ser_a sequence", 32'(seq8), 32'h31);
        do_op8(8'hC8, 8'h64, 8'h2C, 1'b1, "200+100");
        do_op8(8'hFF, 8'h01, 8'h00, 1'b1, "ff+01");
        do_op8(8'h00, 8'h00, 8'h00, 1'b0, "0+0");

        // Start pulsed with new operands while the first operation is shifting.
        wait_idle8();
        bus8.op_a = 8'h31; bus8.op_b = 8'h14; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.op_a = 8'h01; bus8.op_b = 8'h01; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus8.done) pulses++;
        end
        chk("ignored start pulses", 32'(pulses), 32'd1);
        chk("ignored start sum",    32'(bus8.sum), 32'h45);

        // Start held high: one operation every WIDTH+2 cycles.
        wait_idle8();
        bus8.op_a = 8'h7F; bus8.op_b = 8'h01; bus8.start = 1'b1;
        dk.delete();
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (bus8.done) begin
                dk.push_back(k);
                chk("held sum",   32'(bus8.sum),       32'h80);
                chk("held carry", 32'(bus8.carry_out), 32'd0);
            end
        end
        bus8.start = 1'b0;
        chk("held pulse count", 32'(dk.size()), 32'd3);
        if (dk.size() >= 3) begin
            chk("held first done", 32'(dk[0]), 32'd9);
            chk("held period 1",   32'(dk[1] - dk[0]), 32'd10);
            chk("held period 2",   32'(dk[2] - dk[1]), 32'd10);
        end

        // Asynchronous reset three cycles into SHIFT, released with start already high.
        wait_idle8();
        bus8.op_a = 8'h55; bus8.op_b = 8'hAA; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset busy",    32'(bus8.busy),      32'd0);
        chk("midreset done",    32'(bus8.done),      32'd0);
        chk("midreset sum",     32'(bus8.sum),       32'd0);
        chk("midreset carry",   32'(bus8.carry_out), 32'd0);
        chk("midreset ser_rst", 32'(bus8.ser_rst),   32'd1);
        bus8.op_a = 8'h0A; bus8.op_b = 8'h05; bus8.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_done8(8'h0F, 1'b0, 1'b0, "post-reset");

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            re = 9'(ra) + 9'(rb);
            do_op8(ra, rb, re[7:0], re[8], "rand8");
        end

        for (int i = 0; i < 150; i++) begin
            do_op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        do_op16(16'hFFFF, 16'h0001);
        do_op16(16'h8000, 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
